// File: rtl/aes_pkg.sv
// Shared AES decrypt types and constants.
// Byte type, state enum and GF(2^8) helpers.
package aes_pkg;

    typedef logic [7:0] byte_t;

    localparam int NUM_BYTES = 16;
    localparam byte_t AFFINE_C = 8'h63;
    localparam byte_t INV_AFFINE_C = 8'h05;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic byte_t xtime(input byte_t a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic byte_t gf_mul(input byte_t a, input byte_t b);
        byte_t p;
        byte_t t;
        p = '0;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    function automatic byte_t fwd_affine(input byte_t b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
                 ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]}
                 ^ AFFINE_C;
    endfunction

endpackage

// File: rtl/inv_sbox.sv
// AES inverse S-box, purely combinational.
// Inverse affine map, then GF(2^8) inverse as a^254.
module inv_sbox
    import aes_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] y
);

    byte_t t;
    byte_t p;
    byte_t acc;

    // a^254 = a^2 * a^4 * ... * a^128; zero maps to zero
    always_comb begin
        t = {a[6:0], a[7]} ^ {a[4:0], a[7:5]}
          ^ {a[1:0], a[7:2]} ^ INV_AFFINE_C;
        p = t;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            acc = gf_mul(acc, p);
        end
        y = acc;
    end

endmodule

// File: rtl/inv_sub_bytes_iter.sv
// Iterative InvSubBytes: LANES bytes per clock
// through a shared pool of inverse S-boxes.
module inv_sub_bytes_iter
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] x,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [127:0] z,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy
);

    localparam int STEPS = NUM_BYTES / LANES;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 ||
          LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("inv_sub_bytes_iter: LANES must be 1,2,4,8,16");
    end

    state_t state, state_n;
    logic [127:0] sbuf, sbuf_n;
    logic [CNT_W-1:0] cnt, cnt_n;

    byte_t lane_in [LANES];
    byte_t lane_out [LANES];

    // pick the LANES bytes addressed by the step counter
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_in[l] = sbuf[(int'(cnt) * LANES + l) * 8 +: 8];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        inv_sbox u_sbox (
            .a(lane_in[g]),
            .y(lane_out[g])
        );
    end

    // state, buffer and step counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sbuf  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            sbuf  <= sbuf_n;
            cnt   <= cnt_n;
        end
    end

    // next-state logic and lane write-back
    always_comb begin
        state_n = state;
        sbuf_n  = sbuf;
        cnt_n   = cnt;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    sbuf_n  = x;
                    cnt_n   = '0;
                    state_n = RUN;
                end
            end
            RUN: begin
                for (int l = 0; l < LANES; l++) begin
                    sbuf_n[(int'(cnt) * LANES + l) * 8 +: 8] = lane_out[l];
                end
                if (cnt == LAST) begin
                    cnt_n   = '0;
                    state_n = DONE;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE) & ~rst;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign z         = sbuf;

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Bench for inv_sub_bytes_iter over LANES 1..16.
// Reference: table-driven S-box built by brute force.
module tb_inv_sub_bytes_iter;

    localparam int NI = 5;
    localparam int LV [NI] = '{1, 2, 4, 8, 16};
    localparam int P = 2;

    logic clk = 1'b0;
    logic rst;
    logic [127:0] x;
    logic in_valid;
    logic out_ready;

    logic [127:0] zs [NI];
    logic ovs [NI];
    logic irs [NI];
    logic bs [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        inv_sub_bytes_iter #(.LANES(LV[g])) dut (
            .clk      (clk),
            .rst      (rst),
            .x        (x),
            .in_valid (in_valid),
            .in_ready (irs[g]),
            .z        (zs[g]),
            .out_valid(ovs[g]),
            .out_ready(out_ready),
            .busy     (bs[g])
        );
    end

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [7:0] sbox [256];
    logic [7:0] isbox [256];
    logic [127:0] r_z [NI];
    int r_lat [NI];

    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [15:0] prod;
        prod = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) prod = prod ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--)
            if (prod[i]) prod = prod ^ (16'h011b << (i - 8));
        return prod[7:0];
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic init_tables();
        logic [7:0] inv;
        for (int b = 0; b < 256; b++) begin
            inv = 8'h00;
            for (int c = 1; c < 256; c++)
                if (gmul(8'(b), 8'(c)) == 8'h01) inv = 8'(c);
            sbox[b] = inv ^ rotl(inv, 1) ^ rotl(inv, 2)
                    ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
        for (int b = 0; b < 256; b++) isbox[sbox[b]] = 8'(b);
    endtask

    function automatic logic [127:0] sub_bytes(input logic [127:0] v);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox[v[8*i +: 8]];
        return o;
    endfunction

    function automatic logic [127:0] inv_ref(input logic [127:0] v);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = isbox[v[8*i +: 8]];
        return o;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [127:0] v);
        x = v;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic run_one(input logic [127:0] v);
        bit seen [NI];
        int n;
        for (int g = 0; g < NI; g++) begin
            seen[g] = 0;
            r_lat[g] = -1;
            r_z[g] = '0;
        end
        accept(v);
        n = 0;
        for (int e = 1; e <= 40 && n < NI; e++) begin
            tick();
            for (int g = 0; g < NI; g++) begin
                if (ovs[g] && !seen[g]) begin
                    seen[g] = 1;
                    r_lat[g] = e;
                    r_z[g] = zs[g];
                    n++;
                end
            end
        end
        tick();
        total++;
        if (n != NI) begin
            bad++;
            $display("FAIL run_timeout: done=%0d need=%0d", n, NI);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        x = '0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        #2;
        rst = 1'b1;
        #2;
        for (int g = 0; g < NI; g++) begin
            total++;
            if ({irs[g], ovs[g], bs[g]} !== 3'b000 || zs[g] !== '0) begin
                bad++;
                $display("FAIL reset_state[%0d]: ir/ov/busy=%b%b%b z=%h want 000 z=0",
                         LV[g], irs[g], ovs[g], bs[g], zs[g]);
            end
        end
        tick();
        tick();
        rst = 1'b0;
        #1;
        for (int g = 0; g < NI; g++) begin
            total++;
            if (irs[g] !== 1'b1 || ovs[g] !== 1'b0) begin
                bad++;
                $display("FAIL reset_release[%0d]: in_ready=%b out_valid=%b want 1 0",
                         LV[g], irs[g], ovs[g]);
            end
        end
    endtask

    task automatic test_zero();
        logic [127:0] v;
        v = {16{8'h63}};
        run_one(v);
        total++;
        if (r_z[P] !== '0) begin
            bad++;
            $display("FAIL zero_value: got=%h want=0", r_z[P]);
        end
        total++;
        if (r_lat[P] !== 4) begin
            bad++;
            $display("FAIL zero_latency: got=%0d want=4", r_lat[P]);
        end
    endtask

    task automatic test_order();
        logic [127:0] v;
        logic [127:0] want;
        v = {4{32'hed16007c}};
        want = {4{32'h53ff5201}};
        run_one(v);
        for (int g = 0; g < NI; g++) begin
            total++;
            if (r_z[g] !== want) begin
                bad++;
                $display("FAIL byte_order[%0d]: got=%h want=%h",
                         LV[g], r_z[g], want);
            end
        end
    endtask

    task automatic test_roundtrip();
        logic [127:0] v;
        for (int k = 0; k < 1000; k++) begin
            v = rnd128();
            run_one(sub_bytes(v));
            for (int g = 0; g < NI; g++) begin
                total++;
                if (r_z[g] !== v) begin
                    bad++;
                    $display("FAIL roundtrip[%0d] #%0d: got=%h want=%h",
                             LV[g], k, r_z[g], v);
                end
                total++;
                if (r_lat[g] !== 16 / LV[g]) begin
                    bad++;
                    $display("FAIL latency[%0d] #%0d: got=%0d want=%0d",
                             LV[g], k, r_lat[g], 16 / LV[g]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] v;
        logic [127:0] want;
        logic [127:0] hold;
        bit ok;
        v = rnd128();
        want = v;
        out_ready = 1'b0;
        accept(sub_bytes(v));
        repeat (4) tick();
        total++;
        if (ovs[P] !== 1'b1 || zs[P] !== want) begin
            bad++;
            $display("FAIL bp_done: out_valid=%b z=%h want 1 %h",
                     ovs[P], zs[P], want);
        end
        hold = want;
        ok = 1;
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'($urandom & 1);
            x = rnd128();
            tick();
            if (zs[P] !== hold || ovs[P] !== 1'b1 || irs[P] !== 1'b0)
                ok = 0;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL bp_hold: z=%h ov=%b ir=%b want z=%h 1 0",
                     zs[P], ovs[P], irs[P], hold);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        total++;
        if (irs[P] !== 1'b1 || ovs[P] !== 1'b0) begin
            bad++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b want 1 0",
                     irs[P], ovs[P]);
        end
        repeat (20) tick();
    endtask

    task automatic test_reset_mid();
        logic [127:0] v;
        bit pulse;
        v = rnd128();
        accept(sub_bytes(v));
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (ovs[P] !== 1'b0 || zs[P] !== '0 || bs[P] !== 1'b0 ||
            irs[P] !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: ov=%b z=%h busy=%b ir=%b want 0 0 0 0",
                     ovs[P], zs[P], bs[P], irs[P]);
        end
        tick();
        tick();
        rst = 1'b0;
        pulse = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            for (int g = 0; g < NI; g++)
                if (ovs[g] !== 1'b0 || bs[g] !== 1'b0) pulse = 1;
        end
        total++;
        if (pulse) begin
            bad++;
            $display("FAIL mid_reset_pulse: out_valid or busy seen=1 want 0");
        end
        v = rnd128();
        run_one(sub_bytes(v));
        for (int g = 0; g < NI; g++) begin
            total++;
            if (r_z[g] !== v) begin
                bad++;
                $display("FAIL mid_reset_fresh[%0d]: got=%h want=%h",
                         LV[g], r_z[g], v);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] cur;
        logic [127:0] exp_q [$];
        int acc_cyc [$];
        logic [127:0] want;
        bit will_acc;
        int nacc;
        int nres;
        int cyc;
        out_ready = 1'b1;
        cur = rnd128();
        x = sub_bytes(cur);
        in_valid = 1'b1;
        nacc = 0;
        nres = 0;
        cyc = 0;
        while ((nacc < 5 || nres < 5) && cyc < 200) begin
            will_acc = irs[P] && in_valid;
            tick();
            cyc++;
            if (will_acc) begin
                exp_q.push_back(cur);
                acc_cyc.push_back(cyc);
                nacc++;
                if (nacc == 5) begin
                    in_valid = 1'b0;
                end else begin
                    cur = rnd128();
                    x = sub_bytes(cur);
                end
            end
            if (ovs[P]) begin
                nres++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL b2b_extra: z=%h with nothing pending", zs[P]);
                end else begin
                    want = exp_q.pop_front();
                    if (zs[P] !== want) begin
                        bad++;
                        $display("FAIL b2b_value: got=%h want=%h", zs[P], want);
                    end
                end
            end
        end
        total++;
        if (nacc != 5 || nres != 5) begin
            bad++;
            $display("FAIL b2b_timeout: acc=%0d res=%0d want 5 5", nacc, nres);
        end
        for (int i = 0; i + 1 < acc_cyc.size(); i++) begin
            total++;
            if (acc_cyc[i+1] - acc_cyc[i] != 6) begin
                bad++;
                $display("FAIL b2b_gap: got=%0d want=6",
                         acc_cyc[i+1] - acc_cyc[i]);
            end
        end
        in_valid = 1'b0;
        repeat (20) tick();
    endtask

    initial begin
        init_tables();
        test_reset();
        test_zero();
        test_order();
        test_roundtrip();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inv_sub_bytes_iter.md
Name: inv_sub_bytes_iter

Overview:
Iterative InvSubBytes engine for the AES decrypt datapath. It is the inverse of the encrypt-side SubBytes stage.
- Accepts a 128-bit state over a valid/ready handshake.
- Applies the AES inverse S-box to all 16 bytes, LANES bytes per clock, using a shared pool of inverse S-box instances.
- Returns the result over a second valid/ready handshake.
- Trades area for latency in the decrypt round loop.

Parameters:
LANES, 4, number of inv_sbox instances and bytes transformed per cycle; legal values 1, 2, 4, 8, 16 (elaboration error otherwise)
STEPS, 16/LANES (derived, localparam), cycles spent in RUN
CNT_W, max(1, clog2(STEPS)) (derived, localparam), step counter width

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
x  input  128  input state; byte i = x[8i+7:8i]; byte ordering identical to encrypt SubBytes
in_valid  input  1  x is valid
in_ready  output  1  block can accept a state
z  output  128  transformed state, same byte ordering as x
out_valid  output  1  z is valid
out_ready  input  1  consumer accepts z
busy  output  1  high in RUN or DONE

Behaviour:
- States: IDLE, RUN, DONE. Registers: state, buf[127:0], cnt[CNT_W-1:0].
- Reset (async assert, takes effect immediately): state=IDLE, buf=0, cnt=0. Outputs during and after reset: out_valid=0, z=0, busy=0.
- in_ready = (state==IDLE) & ~rst, so in_ready is 0 while rst is high and 1 after reset releases.
- IDLE:
  - Accept when in_valid & in_ready (accepting edge).
  - On accept: buf<=x, cnt<=0, state<=RUN.
  - x is sampled only on the accepting edge; later changes on x are ignored.
- RUN:
  - Each edge, bytes k = cnt*LANES ... cnt*LANES+LANES-1 of buf are replaced by inv_sbox(byte k).
  - All other bytes hold.
  - cnt<=cnt+1, except when cnt==STEPS-1: cnt<=0, state<=DONE.
  - in_valid is ignored (in_ready=0).
- DONE:
  - out_valid=1; z=buf, held stable until the handshake completes.
  - On out_valid & out_ready: state<=IDLE.
  - The next input cannot be accepted on the same edge. in_ready rises the cycle after the handshake.
- Latency: out_valid rises exactly STEPS rising edges after the accepting edge (LANES=4: 4 edges; LANES=16: 1 edge).
- Throughput: one state per STEPS+2 cycles when out_ready is held high.
- z equals buf in every state; out_valid is the only qualifier.
- Backpressure: if out_ready stays low, the block stays in DONE indefinitely with z unchanged.
- Reset mid-operation (RUN or DONE): the partial result is discarded, state returns to IDLE with buf=0, and no out_valid pulse is produced.
- Byte mapping: the inverse S-box is a bijection with InvSbox(Sbox(b))=b for all 256 b. For any x, inv_sub_bytes_iter(SubBytes(x))==x.

Decomposition:
- Shared package aes_pkg:
  - byte typedef;
  - NUM_BYTES=16;
  - affine constant 8'h63;
  - inverse-affine constant 8'h05;
  - the state-enum typedef for IDLE/RUN/DONE.
- Sub-module inv_sbox (purely combinational, 8-bit in, 8-bit out):
  - inverse affine transform, then GF(2^8) multiplicative inverse (0 maps to 0);
  - instantiated LANES times through a generate loop.
- Lane byte selection from buf indexed by cnt is a mux in the top module. No further sub-modules.

Test Plan:
- After reset, x=128'h63 repeated in all 16 bytes, in_valid=1 for one cycle, out_ready=1 -> z=all bytes 8'h00; out_valid rises 4 edges after acceptance (LANES=4).
- x bytes 0..15 = 8'h7c,8'h00,8'h16,8'hed, then the same four bytes repeated -> z bytes = 8'h01,8'h52,8'hff,8'h53, repeated in the same order; confirms per-lane byte ordering.
- Round trip: 1000 random x fed through the encrypt SubBytes and then this block, swept over LANES=1,2,4,8,16 -> output == x in every case; latency == 16/LANES edges in every case.
- Backpressure: hold out_ready=0 for 10 cycles in DONE while toggling in_valid and x.
  - z and out_valid stay stable, in_ready stays 0, and the new x is not absorbed.
  - After out_ready=1 for one edge, in_ready=1 on the following cycle.
- Reset mid-RUN: assert rst at step 2 of 4 -> state IDLE, out_valid=0, z=128'h0 immediately, with no out_valid pulse afterwards. A fresh input after reset release produces the correct result.
- Back-to-back inputs with in_valid held high and out_ready held high -> consecutive acceptances are exactly STEPS+2 cycles apart and all results are correct.
